// File: rtl/tlb_maint_sequencer.sv
// Sequences one TLB maintenance op (search/read/write/fill/invalidate) against the MMU
// and turns the MMU result into a single CSR write-back plus a completion pulse.
module tlb_maint_sequencer #(
   parameter int TLB_ENTRY_NUM = 32,
   parameter int RSP_LAT       = 1,
   localparam int IDX_W        = $clog2(TLB_ENTRY_NUM)
) (
   input  logic              clk,
   input  logic              a_rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_op_i,
   input  logic [4:0]        req_invop_i,
   input  logic [9:0]        req_asid_i,
   input  logic [18:0]       req_vpn_i,
   input  logic [31:0]       csr_tlbidx_i,
   output logic              tlbsrch_en_o,
   output logic              tlbrd_en_o,
   output logic              tlbwr_en_o,
   output logic              tlbfill_en_o,
   output logic              invtlb_en_o,
   output logic [IDX_W-1:0]  rand_idx_o,
   output logic [4:0]        invtlb_op_o,
   output logic [9:0]        invtlb_asid_o,
   output logic [18:0]       invtlb_vpn_o,
   input  logic              tlbsrch_found_i,
   input  logic [IDX_W-1:0]  tlbsrch_idx_i,
   input  logic [31:0]       tlbehi_i,
   input  logic [31:0]       tlbelo0_i,
   input  logic [31:0]       tlbelo1_i,
   input  logic [31:0]       tlbidx_i,
   input  logic [9:0]        tlbasid_i,
   output logic [4:0]        csr_we_o,
   output logic [31:0]       tlbidx_wdata_o,
   output logic [31:0]       tlbehi_wdata_o,
   output logic [31:0]       tlbelo0_wdata_o,
   output logic [31:0]       tlbelo1_wdata_o,
   output logic [9:0]        asid_wdata_o,
   output logic              done_o,
   output logic              ine_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   state_t     state;
   logic [2:0] op_q;
   logic [1:0] wait_cnt;
   logic [4:0] lfsr;
   logic       illegal;
   logic       unused_tlbidx_bits;

   assign illegal = (req_op_i > OP_INV) || ((req_op_i == OP_INV) && (req_invop_i > 5'd6));
   assign unused_tlbidx_bits = ^{tlbidx_i[30], tlbidx_i[23:0]};

   // Free-running x^5+x^3+1 Fibonacci LFSR: shift left, feedback = bit4 ^ bit2
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) lfsr <= 5'b00001;
      else       lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         state           <= IDLE;
         op_q            <= 3'd0;
         wait_cnt        <= 2'd0;
         req_ready_o     <= 1'b1;
         tlbsrch_en_o    <= 1'b0;
         tlbrd_en_o      <= 1'b0;
         tlbwr_en_o      <= 1'b0;
         tlbfill_en_o    <= 1'b0;
         invtlb_en_o     <= 1'b0;
         rand_idx_o      <= '0;
         invtlb_op_o     <= 5'd0;
         invtlb_asid_o   <= 10'd0;
         invtlb_vpn_o    <= 19'd0;
         csr_we_o        <= 5'd0;
         tlbidx_wdata_o  <= 32'd0;
         tlbehi_wdata_o  <= 32'd0;
         tlbelo0_wdata_o <= 32'd0;
         tlbelo1_wdata_o <= 32'd0;
         asid_wdata_o    <= 10'd0;
         done_o          <= 1'b0;
         ine_o           <= 1'b0;
      end else begin
         tlbsrch_en_o <= 1'b0;
         tlbrd_en_o   <= 1'b0;
         tlbwr_en_o   <= 1'b0;
         tlbfill_en_o <= 1'b0;
         invtlb_en_o  <= 1'b0;
         csr_we_o     <= 5'd0;
         done_o       <= 1'b0;
         ine_o        <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  op_q          <= req_op_i;
                  invtlb_op_o   <= req_invop_i;
                  invtlb_asid_o <= req_asid_i;
                  invtlb_vpn_o  <= req_vpn_i;
                  rand_idx_o    <= IDX_W'(lfsr);
                  req_ready_o   <= 1'b0;
                  if (illegal) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     ine_o  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                     case (req_op_i)
                        OP_SRCH: tlbsrch_en_o <= 1'b1;
                        OP_RD:   tlbrd_en_o   <= 1'b1;
                        OP_WR:   tlbwr_en_o   <= 1'b1;
                        OP_FILL: tlbfill_en_o <= 1'b1;
                        default: invtlb_en_o  <= 1'b1;
                     endcase
                  end
               end
            end
            ISSUE: begin
               if ((op_q == OP_SRCH) || (op_q == OP_RD)) begin
                  state    <= WAIT;
                  wait_cnt <= 2'd0;
               end else begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt == 2'(RSP_LAT - 1)) begin
                  state  <= DONE;
                  done_o <= 1'b1;
                  // MMU result is only guaranteed valid on this last wait cycle
                  if (op_q == OP_SRCH) begin
                     csr_we_o <= 5'b00001;
                     if (tlbsrch_found_i)
                        tlbidx_wdata_o <= {1'b0, csr_tlbidx_i[30:IDX_W], tlbsrch_idx_i};
                     else
                        tlbidx_wdata_o <= {1'b1, csr_tlbidx_i[30:0]};
                  end else begin
                     csr_we_o <= 5'b11111;
                     if (!tlbidx_i[31]) begin
                        tlbidx_wdata_o  <= {2'b00, tlbidx_i[29:24], csr_tlbidx_i[23:0]};
                        tlbehi_wdata_o  <= tlbehi_i;
                        tlbelo0_wdata_o <= tlbelo0_i;
                        tlbelo1_wdata_o <= tlbelo1_i;
                        asid_wdata_o    <= tlbasid_i;
                     end else begin
                        tlbidx_wdata_o  <= {1'b1, csr_tlbidx_i[30], 6'd0, csr_tlbidx_i[23:0]};
                        tlbehi_wdata_o  <= 32'd0;
                        tlbelo0_wdata_o <= 32'd0;
                        tlbelo1_wdata_o <= 32'd0;
                        asid_wdata_o    <= 10'd0;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            DONE: begin
               state       <= IDLE;
               req_ready_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_maint_sequencer.sv
// Scoreboard bench for tlb_maint_sequencer: the driver queues expected MMU pulses and
// CSR write-backs, and a negedge monitor pops and compares them as the DUT produces them.
module tb_tlb_maint_sequencer;

   localparam int TLB_ENTRY_NUM = 32;
   localparam int RSP_LAT       = 1;
   localparam int IDX_W         = 5;

   logic              clk = 1'b0;
   logic              a_rst = 1'b0;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [2:0]        req_op_i;
   logic [4:0]        req_invop_i;
   logic [9:0]        req_asid_i;
   logic [18:0]       req_vpn_i;
   logic [31:0]       csr_tlbidx_i;
   logic              tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o;
   logic [IDX_W-1:0]  rand_idx_o;
   logic [4:0]        invtlb_op_o;
   logic [9:0]        invtlb_asid_o;
   logic [18:0]       invtlb_vpn_o;
   logic              tlbsrch_found_i;
   logic [IDX_W-1:0]  tlbsrch_idx_i;
   logic [31:0]       tlbehi_i, tlbelo0_i, tlbelo1_i, tlbidx_i;
   logic [9:0]        tlbasid_i;
   logic [4:0]        csr_we_o;
   logic [31:0]       tlbidx_wdata_o, tlbehi_wdata_o, tlbelo0_wdata_o, tlbelo1_wdata_o;
   logic [9:0]        asid_wdata_o;
   logic              done_o;
   logic              ine_o;

   tlb_maint_sequencer #(.TLB_ENTRY_NUM(TLB_ENTRY_NUM), .RSP_LAT(RSP_LAT)) dut (
      .clk(clk), .a_rst(a_rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_invop_i(req_invop_i), .req_asid_i(req_asid_i), .req_vpn_i(req_vpn_i),
      .csr_tlbidx_i(csr_tlbidx_i),
      .tlbsrch_en_o(tlbsrch_en_o), .tlbrd_en_o(tlbrd_en_o), .tlbwr_en_o(tlbwr_en_o),
      .tlbfill_en_o(tlbfill_en_o), .invtlb_en_o(invtlb_en_o), .rand_idx_o(rand_idx_o),
      .invtlb_op_o(invtlb_op_o), .invtlb_asid_o(invtlb_asid_o), .invtlb_vpn_o(invtlb_vpn_o),
      .tlbsrch_found_i(tlbsrch_found_i), .tlbsrch_idx_i(tlbsrch_idx_i),
      .tlbehi_i(tlbehi_i), .tlbelo0_i(tlbelo0_i), .tlbelo1_i(tlbelo1_i), .tlbidx_i(tlbidx_i),
      .tlbasid_i(tlbasid_i), .csr_we_o(csr_we_o),
      .tlbidx_wdata_o(tlbidx_wdata_o), .tlbehi_wdata_o(tlbehi_wdata_o),
      .tlbelo0_wdata_o(tlbelo0_wdata_o), .tlbelo1_wdata_o(tlbelo1_wdata_o),
      .asid_wdata_o(asid_wdata_o), .done_o(done_o), .ine_o(ine_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  en;
      int          cyc;
      logic        chk_ridx;
      logic [4:0]  ridx;
      logic        chk_inv;
      logic [4:0]  iop;
      logic [9:0]  iasid;
      logic [18:0] ivpn;
   } en_exp_t;

   typedef struct {
      int          cyc;
      logic        ine;
      logic [4:0]  we;
      logic [31:0] idx, ehi, elo0, elo1;
      logic [9:0]  asid;
   } rsp_exp_t;

   en_exp_t  en_q[$];
   rsp_exp_t rsp_q[$];
   int       n_checks = 0;
   int       n_pass = 0;
   int       cyc;
   logic [4:0] mon_en;
   en_exp_t    mon_e;
   rsp_exp_t   mon_r;

   // Cycles since reset release; indexes the hand-computed LFSR sequence below
   always @(posedge clk or posedge a_rst) begin
      if (a_rst) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // x^5+x^3+1 sequence from seed 1 (shift left, feedback bit4^bit2), worked out by hand
   function automatic logic [4:0] expLfsr(input int n);
      case (n % 31)
         0: return 5'd1;    1: return 5'd2;    2: return 5'd4;    3: return 5'd9;
         4: return 5'd18;   5: return 5'd5;    6: return 5'd11;   7: return 5'd22;
         8: return 5'd12;   9: return 5'd25;  10: return 5'd19;  11: return 5'd7;
        12: return 5'd15;  13: return 5'd31;  14: return 5'd30;  15: return 5'd28;
        16: return 5'd24;  17: return 5'd17;  18: return 5'd3;   19: return 5'd6;
        20: return 5'd13;  21: return 5'd27;  22: return 5'd23;  23: return 5'd14;
        24: return 5'd29;  25: return 5'd26;  26: return 5'd21;  27: return 5'd10;
        28: return 5'd20;  29: return 5'd8;
        default: return 5'd16;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every enable pulse and every done pulse must match the head of its queue
   always @(negedge clk) begin
      if (!a_rst) begin
         mon_en = {invtlb_en_o, tlbfill_en_o, tlbwr_en_o, tlbrd_en_o, tlbsrch_en_o};
         if (mon_en != 5'd0) begin
            if (en_q.size() == 0) begin
               checkOutput("unexpected_en", 32'(mon_en), 32'd0);
            end else begin
               mon_e = en_q.pop_front();
               checkOutput("en_vector", 32'(mon_en), 32'(mon_e.en));
               checkOutput("en_cycle", 32'(cyc), 32'(mon_e.cyc));
               if (mon_e.chk_ridx) checkOutput("rand_idx", 32'(rand_idx_o), 32'(mon_e.ridx));
               if (mon_e.chk_inv) begin
                  checkOutput("invtlb_op", 32'(invtlb_op_o), 32'(mon_e.iop));
                  checkOutput("invtlb_asid", 32'(invtlb_asid_o), 32'(mon_e.iasid));
                  checkOutput("invtlb_vpn", 32'(invtlb_vpn_o), 32'(mon_e.ivpn));
               end
            end
         end
         if (done_o) begin
            if (rsp_q.size() == 0) begin
               checkOutput("unexpected_done", 32'(done_o), 32'd0);
            end else begin
               mon_r = rsp_q.pop_front();
               checkOutput("done_cycle", 32'(cyc), 32'(mon_r.cyc));
               checkOutput("done_ready_low", 32'(req_ready_o), 32'd0);
               checkOutput("ine", 32'(ine_o), 32'(mon_r.ine));
               checkOutput("csr_we", 32'(csr_we_o), 32'(mon_r.we));
               if (mon_r.we[0]) checkOutput("tlbidx_wdata", tlbidx_wdata_o, mon_r.idx);
               if (mon_r.we[1]) checkOutput("tlbehi_wdata", tlbehi_wdata_o, mon_r.ehi);
               if (mon_r.we[2]) checkOutput("tlbelo0_wdata", tlbelo0_wdata_o, mon_r.elo0);
               if (mon_r.we[3]) checkOutput("tlbelo1_wdata", tlbelo1_wdata_o, mon_r.elo1);
               if (mon_r.we[4]) checkOutput("asid_wdata", 32'(asid_wdata_o), 32'(mon_r.asid));
            end
         end else if (csr_we_o != 5'd0) begin
            checkOutput("we_without_done", 32'(csr_we_o), 32'd0);
         end
      end
   end

   // Drives one request, waits (bounded) for acceptance, and queues the expected responses.
   // req_valid_i is left high so back-to-back calls model a held request.
   task automatic applyStimulus(input logic [2:0] op, input logic [4:0] invop,
                                input logic [9:0] asid, input logic [18:0] vpn,
                                input logic [4:0] en, input int lat, input logic ine,
                                input logic [4:0] we, input logic [31:0] idx,
                                input logic [31:0] ehi, input logic [31:0] elo0,
                                input logic [31:0] elo1, input logic [9:0] asid_w);
      en_exp_t  e;
      rsp_exp_t r;
      int       w;
      req_op_i    = op;
      req_invop_i = invop;
      req_asid_i  = asid;
      req_vpn_i   = vpn;
      req_valid_i = 1'b1;
      w = 0;
      while (!req_ready_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready_o) begin
         checkOutput("accept_timeout", 32'(req_ready_o), 32'd1);
         req_valid_i = 1'b0;
         return;
      end
      if (en != 5'd0) begin
         e.en       = en;
         e.cyc      = cyc + 1;
         e.chk_ridx = (op == 3'd3);
         e.ridx     = expLfsr(cyc);
         e.chk_inv  = (op == 3'd4);
         e.iop      = invop;
         e.iasid    = asid;
         e.ivpn     = vpn;
         en_q.push_back(e);
      end
      r.cyc  = cyc + lat;
      r.ine  = ine;
      r.we   = we;
      r.idx  = idx;
      r.ehi  = ehi;
      r.elo0 = elo0;
      r.elo1 = elo1;
      r.asid = asid_w;
      rsp_q.push_back(r);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      req_valid_i = 1'b0; req_op_i = 3'd0; req_invop_i = 5'd0; req_asid_i = 10'd0;
      req_vpn_i = 19'd0; csr_tlbidx_i = 32'd0; tlbsrch_found_i = 1'b0; tlbsrch_idx_i = '0;
      tlbehi_i = 32'd0; tlbelo0_i = 32'd0; tlbelo1_i = 32'd0; tlbidx_i = 32'd0; tlbasid_i = 10'd0;
      #1 a_rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
      checkOutput("rst_enables", 32'({invtlb_en_o, tlbfill_en_o, tlbwr_en_o, tlbrd_en_o, tlbsrch_en_o}), 32'd0);
      checkOutput("rst_done", 32'(done_o), 32'd0);
      checkOutput("rst_ine", 32'(ine_o), 32'd0);
      checkOutput("rst_csr_we", 32'(csr_we_o), 32'd0);
      checkOutput("rst_idx_wdata", tlbidx_wdata_o, 32'd0);
      checkOutput("rst_ehi_wdata", tlbehi_wdata_o, 32'd0);
      checkOutput("rst_elo0_wdata", tlbelo0_wdata_o, 32'd0);
      checkOutput("rst_elo1_wdata", tlbelo1_wdata_o, 32'd0);
      checkOutput("rst_asid_wdata", 32'(asid_wdata_o), 32'd0);
      checkOutput("rst_rand_idx", 32'(rand_idx_o), 32'd0);
      checkOutput("rst_invtlb_ops", 32'({invtlb_op_o, invtlb_asid_o} | 15'(invtlb_vpn_o)), 32'd0);
      #1 a_rst = 1'b0;
      @(negedge clk);

      // Search hits: NE cleared, index field replaced by the hit index
      tlbsrch_found_i = 1'b1; tlbsrch_idx_i = 5'd5; csr_tlbidx_i = 32'h8000_0000;
      applyStimulus(3'd0, 5'd0, 10'd0, 19'd0, 5'b00001, 2 + RSP_LAT, 1'b0, 5'b00001,
                    32'h0000_0005, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(2);
      tlbsrch_idx_i = 5'h0A; csr_tlbidx_i = 32'h3A00_0040;
      applyStimulus(3'd0, 5'd0, 10'd0, 19'd0, 5'b00001, 2 + RSP_LAT, 1'b0, 5'b00001,
                    32'h3A00_004A, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(2);
      // Search miss: only NE set
      tlbsrch_found_i = 1'b0; csr_tlbidx_i = 32'h0C00_0007;
      applyStimulus(3'd0, 5'd0, 10'd0, 19'd0, 5'b00001, 2 + RSP_LAT, 1'b0, 5'b00001,
                    32'h8C00_0007, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(2);

      // Read of a valid entry, then of an invalid one
      tlbidx_i = 32'h0C00_0000; tlbehi_i = 32'h1234_6000; tlbelo0_i = 32'h00AB_C0DF;
      tlbelo1_i = 32'h0012_3450; tlbasid_i = 10'h3; csr_tlbidx_i = 32'h8000_0003;
      applyStimulus(3'd1, 5'd0, 10'd0, 19'd0, 5'b00010, 2 + RSP_LAT, 1'b0, 5'b11111,
                    32'h0C00_0003, 32'h1234_6000, 32'h00AB_C0DF, 32'h0012_3450, 10'h3);
      idle(2);
      tlbidx_i = 32'h8C00_0000; csr_tlbidx_i = 32'h4F00_0012;
      applyStimulus(3'd1, 5'd0, 10'd0, 19'd0, 5'b00010, 2 + RSP_LAT, 1'b0, 5'b11111,
                    32'hC000_0012, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(2);

      applyStimulus(3'd2, 5'd0, 10'd0, 19'd0, 5'b00100, 2, 1'b0, 5'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(1);

      // Three fills with the request held high across ops
      repeat (3)
         applyStimulus(3'd3, 5'd0, 10'd0, 19'd0, 5'b01000, 2, 1'b0, 5'd0,
                       32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(3);

      // Illegal invop and illegal op complete in one cycle with ine
      applyStimulus(3'd4, 5'd7, 10'h1, 19'h1, 5'd0, 1, 1'b1, 5'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(2);
      applyStimulus(3'd5, 5'd0, 10'd0, 19'd0, 5'd0, 1, 1'b1, 5'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(2);
      applyStimulus(3'd4, 5'd5, 10'h2A, 19'h1_0000, 5'b10000, 2, 1'b0, 5'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(3);

      // Reset during the wait of a read: its done and write-back must never appear
      tlbidx_i = 32'h0C00_0000;
      applyStimulus(3'd1, 5'd0, 10'd0, 19'd0, 5'b00010, 2 + RSP_LAT, 1'b0, 5'b11111,
                    32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      req_valid_i = 1'b0;
      @(negedge clk);
      #1 a_rst = 1'b1;
      rsp_q.delete();
      en_q.delete();
      @(negedge clk);
      checkOutput("midrst_done", 32'(done_o), 32'd0);
      checkOutput("midrst_csr_we", 32'(csr_we_o), 32'd0);
      checkOutput("midrst_ready", 32'(req_ready_o), 32'd1);
      #1 a_rst = 1'b0;
      // First fill after release must draw index 1 (LFSR back at its seed)
      applyStimulus(3'd3, 5'd0, 10'd0, 19'd0, 5'b01000, 2, 1'b0, 5'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 10'd0);
      idle(4);
      checkOutput("post_ready", 32'(req_ready_o), 32'd1);

      for (int i = 0; i < 20 && (en_q.size() != 0 || rsp_q.size() != 0); i++) @(negedge clk);
      checkOutput("en_queue_drained", 32'(en_q.size()), 32'd0);
      checkOutput("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tlb_maint_sequencer.md
Name: tlb_maint_sequencer

Overview:
- Initiator for the MMU TLB-maintenance port. Accepts one TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB request at a time from the commit stage.
- Drives the MMU enable pulses and operands, waits for the MMU result, then produces a single CSR write-back (TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID) and a completion pulse.
- Owns the TLBFILL random-index generator.

Parameters:
- TLB_ENTRY_NUM, 32: TLB entries. IDX_W = $clog2(TLB_ENTRY_NUM).
- RSP_LAT, 1: cycles from MMU enable pulse to valid search/read result (legal range 1..3).

Ports:
- clk  in  1  clock
- a_rst  in  1  asynchronous reset, active-high
- req_valid_i  in  1  op request
- req_ready_o  out  1  high only in IDLE
- req_op_i  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV; 5..7 illegal
- req_invop_i  in  5  INVTLB op
- req_asid_i  in  10  INVTLB asid
- req_vpn_i  in  19  INVTLB vppn
- csr_tlbidx_i  in  32  current TLBIDX CSR
- tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o  out  1 each  one-cycle MMU pulses
- rand_idx_o  out  IDX_W  fill index to MMU
- invtlb_op_o  out  5  registered operand
- invtlb_asid_o  out  10  registered operand
- invtlb_vpn_o  out  19  registered operand
- tlbsrch_found_i  in  1  MMU search result
- tlbsrch_idx_i  in  IDX_W  MMU search result
- tlbehi_i, tlbelo0_i, tlbelo1_i, tlbidx_i  in  32 each  MMU read result
- tlbasid_i  in  10  MMU read result
- csr_we_o  out  5  one-hot-per-CSR write strobes {asid,elo1,elo0,ehi,idx}
- tlbidx_wdata_o, tlbehi_wdata_o, tlbelo0_wdata_o, tlbelo1_wdata_o  out  32 each  CSR write data
- asid_wdata_o  out  10  CSR write data
- done_o  out  1  completion pulse
- ine_o  out  1  illegal op/invop, valid with done_o

Behaviour:
- Reset: FSM=IDLE; req_ready_o=1; every other output 0; LFSR=5'b00001.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, req_valid_i & req_ready_o:
  - Latch op and operands.
  - If op>4, or op==INV with invop>6: go directly to DONE with ine_o=1 and no MMU pulse.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): assert exactly one enable matching op.
  - invtlb_* outputs hold the latched operands from ISSUE until the next accept.
  - rand_idx_o equals the LFSR value sampled at accept; it is held stable through ISSUE.
  - SRCH/RD go to WAIT. WR/FILL/INV go to DONE.
- WAIT: counter runs RSP_LAT cycles. On the last WAIT cycle, sample the MMU result inputs, then go to DONE.
- DONE (1 cycle): done_o=1 and csr_we_o per op, then IDLE. No CSR writes for WR/FILL/INV/illegal.
  - SRCH found: write idx with {NE=0, csr_tlbidx_i[30:IDX_W], tlbsrch_idx_i}.
  - SRCH miss: write idx with csr_tlbidx_i and bit31=1. Index field unchanged.
  - RD, tlbidx_i[31]==0: write all 5 CSRs.
    - ehi/elo0/elo1/asid = MMU values.
    - idx = {0, 1'b0, tlbidx_i[29:24], csr_tlbidx_i[23:0]}.
  - RD, tlbidx_i[31]==1: write all 5 CSRs.
    - idx = {1, csr_tlbidx_i[30:0] with PS[29:24]=0}.
    - ehi/elo0/elo1/asid = 0.
- Handshake: req_ready_o=0 outside IDLE. A request held during busy is accepted on the first IDLE cycle. Op latency: accept→done is 2 cycles for WR/FILL/INV, 2+RSP_LAT for SRCH/RD, 1 for illegal.
- LFSR: 5-bit Fibonacci, x^5+x^3+1, advances every cycle including while busy; never 0. Index = low IDX_W bits.
- Mid-operation reset: returns to IDLE immediately. No enable or done pulse is emitted after reset release.
- Enable pulses are never asserted concurrently, and never for more than one cycle.

Test Plan:
- Reset: a_rst=1 → all outputs 0, req_ready_o=1. Release; SRCH with tlbsrch_found_i=1, idx=5, csr_tlbidx_i=0x8000_0000 → tlbsrch_en_o pulses at cycle+1; done_o at cycle 2+RSP_LAT; csr_we_o=5'b00001; tlbidx_wdata_o=0x0000_0005.
- SRCH miss, csr_tlbidx_i=0x0C00_0007 → tlbidx_wdata_o=0x8C00_0007.
- RD with tlbidx_i=0x0C00_0000, tlbehi_i=0x1234_6000, tlbasid_i=0x3 → csr_we_o=5'b11111; ehi=0x1234_6000; asid=0x3; idx NE=0, PS=0x0C. Repeat with tlbidx_i[31]=1 → ehi/elo0/elo1/asid = 0, idx bit31=1.
- Back-to-back FILL×3 with req_valid_i held → one tlbfill_en_o per op; rand_idx_o values distinct, non-zero, and follow the LFSR sequence from seed 1; req_ready_o low 2 cycles per op.
- INV invop=7 → no invtlb_en_o; done_o with ine_o=1 one cycle after accept. INV invop=5, asid=0x2A, vpn=0x1_0000 → operands stable on invtlb_* outputs during the invtlb_en_o pulse.
- Assert a_rst during WAIT of a RD → no done_o and no csr_we_o; after release req_ready_o=1 and LFSR=1.
